// File: rtl/branch_predict_unit_pkg.sv
// Shared constants for the branch predictor: datapath width, PC step and
// the reset/allocation values of the saturating direction counters.
package branch_predict_unit_pkg;
    localparam int WORD_DEF = 32;
    localparam int PC_STEP  = 4;

    // Weakly not-taken: the value every counter returns to on reset.
    function automatic int cnt_wnt(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    // Weakly taken: the value given to a freshly allocated entry.
    function automatic int cnt_wt(input int cnt_w);
        return 1 << (cnt_w - 1);
    endfunction
endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// Saturating up/down counter step used on the BTB update path.
module branch_predict_unit_sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    always_comb begin
        cnt_o = cnt_i;
        if (inc_i) begin
            if (!(&cnt_i)) cnt_o = cnt_i + 1'b1;
        end else begin
            if (|cnt_i) cnt_o = cnt_i - 1'b1;
        end
    end
endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with per-entry tag, target and direction counter; IF-side
// zero-latency lookup, EX-side redirect generation and table/perf-counter update.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int WORD    = WORD_DEF,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [WORD-1:0] if_pc,
    output logic            if_predict,
    output logic [WORD-1:0] if_next_pc,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_taken,
    input  logic            ex_predict,
    input  logic [WORD-1:0] ex_pred_pc,
    input  logic [WORD-1:0] ex_pc,
    input  logic [WORD-1:0] ex_target,
    output logic            ex_redirect,
    output logic [WORD-1:0] ex_redirect_pc,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(cnt_wnt(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(cnt_wt(CNT_W));

    logic [ENTRIES-1:0]                 valid_q;
    logic [ENTRIES-1:0][TAG_W-1:0]      tag_q;
    logic [ENTRIES-1:0][WORD-1:0]       tgt_q;
    logic [ENTRIES-1:0][CNT_W-1:0]      cnt_q;
    logic [31:0]                        branch_cnt_q, branch_cnt_d;
    logic [31:0]                        mispred_cnt_q, mispred_cnt_d;

    // Lookup reads the flops directly, so a same-cycle update is not visible.
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    assign if_idx     = if_pc[2 +: IDX_W];
    assign if_tag     = if_pc[2+IDX_W +: TAG_W];
    assign if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign if_predict = if_hit && cnt_q[if_idx][CNT_W-1];
    assign if_next_pc = if_predict ? tgt_q[if_idx] : if_pc + WORD'(PC_STEP);

    // Comparing the carried prediction against the true next PC catches
    // direction, target and alias misses with a single check.
    logic [WORD-1:0] ex_seq_pc, correct_pc;
    assign ex_seq_pc      = ex_pc + WORD'(PC_STEP);
    assign correct_pc     = (ex_is_branch && ex_taken) ? ex_target : ex_seq_pc;
    assign ex_redirect    = ex_valid && (ex_pred_pc != correct_pc);
    assign ex_redirect_pc = ex_valid ? correct_pc : ex_seq_pc;

    logic unused_ex_predict;
    assign unused_ex_predict = ex_predict;

    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic [CNT_W-1:0] cnt_upd;
    assign ex_idx = ex_pc[2 +: IDX_W];
    assign ex_tag = ex_pc[2+IDX_W +: TAG_W];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    branch_predict_unit_sat_counter #(.CNT_W(CNT_W)) u_sat (
        .cnt_i (cnt_q[ex_idx]),
        .inc_i (ex_taken),
        .cnt_o (cnt_upd)
    );

    assign branch_cnt_d  = branch_cnt_q + 32'((ex_valid && ex_is_branch) ? 1 : 0);
    assign mispred_cnt_d = mispred_cnt_q + 32'(ex_redirect ? 1 : 0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q       <= '0;
            tag_q         <= '0;
            tgt_q         <= '0;
            cnt_q         <= {ENTRIES{CNT_INIT}};
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (ex_valid) begin
                if (ex_is_branch) begin
                    if (ex_hit) begin
                        cnt_q[ex_idx] <= cnt_upd;
                    end else if (ex_taken) begin
                        valid_q[ex_idx] <= 1'b1;
                        tag_q[ex_idx]   <= ex_tag;
                        cnt_q[ex_idx]   <= CNT_ALLOC;
                    end
                    if (ex_taken) tgt_q[ex_idx] <= ex_target;
                end else if (ex_hit) begin
                    valid_q[ex_idx] <= 1'b0;
                end
            end
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
endmodule
